// File: rtl/tap_mem_stream_reader_pkg.sv
// Shared types and default constants for the tap-memory stream reader.
package tap_mem_pkg;

   typedef enum logic [2:0] {
      S_IDLE,
      S_REQ,
      S_WAIT,
      S_SEND,
      S_DONE
   } state_t;

   localparam int P_MEM_ADDR_WD_DEF = 12;
   localparam int P_MEM_WD_DEF      = 72;
   localparam int P_NBR_URAM_DEF    = 2;
   localparam int P_DATA_WD_DEF     = 48;
   localparam int P_TIMEOUT_DEF     = 255;

   function automatic int words_per_line(input int line_wd, input int data_wd);
      return line_wd / data_wd;
   endfunction

endpackage

// File: rtl/tap_mem_stream_reader_if.sv
// Tap-memory request/return bus and output word stream, grouped as interfaces.
interface tap_mem_if #(
   parameter int P_MEM_ADDR_WD = 12,
   parameter int P_LINE_WD     = 144
);
   logic                     o_data_request;
   logic [P_MEM_ADDR_WD-1:0] o_addr_tap_mem;
   logic [P_LINE_WD-1:0]     i_data_tap_mem;
   logic                     i_data_tap_mem_valid;
   logic                     i_data_tap_mem_busy;

   modport master (
      output o_data_request, o_addr_tap_mem,
      input  i_data_tap_mem, i_data_tap_mem_valid, i_data_tap_mem_busy
   );
   modport slave (
      input  o_data_request, o_addr_tap_mem,
      output i_data_tap_mem, i_data_tap_mem_valid, i_data_tap_mem_busy
   );
endinterface

interface tap_stream_if #(
   parameter int P_DATA_WD = 48
);
   logic [P_DATA_WD-1:0] o_tdata;
   logic                 o_tvalid;
   logic                 i_tready;
   logic                 o_tlast;

   modport master (output o_tdata, o_tvalid, o_tlast, input i_tready);
   modport slave  (input o_tdata, o_tvalid, o_tlast, output i_tready);
endinterface

// File: rtl/tap_mem_stream_reader_serializer.sv
// Captures one memory line and streams it out LSB slice first under ready/valid.
module tap_mem_line_serializer
   import tap_mem_pkg::*;
#(
   parameter int P_LINE_WD = 144,
   parameter int P_DATA_WD = 48
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 load,
   input  logic [P_LINE_WD-1:0] line,
   input  logic                 last_line,
   output logic                 line_done,
   tap_stream_if.master         axis
);

   localparam int WPL = words_per_line(P_LINE_WD, P_DATA_WD);
   localparam int IW  = (WPL > 1) ? $clog2(WPL) : 1;
   localparam logic [IW-1:0] LAST_IDX = IW'(WPL - 1);

   logic [P_LINE_WD-1:0] line_r;
   logic [IW-1:0]        idx;
   logic                 last_r;
   logic                 accept;

   assign accept = axis.o_tvalid & axis.i_tready;

   // The line is shifted down on each accepted word, so the current word is always the low slice.
   always_ff @(posedge clk) begin
      if (rst) begin
         line_r        <= '0;
         idx           <= '0;
         last_r        <= 1'b0;
         axis.o_tvalid <= 1'b0;
      end else if (load) begin
         line_r        <= line;
         idx           <= '0;
         last_r        <= last_line;
         axis.o_tvalid <= 1'b1;
      end else if (accept) begin
         line_r <= line_r >> P_DATA_WD;
         if (idx == LAST_IDX) begin
            idx           <= '0;
            axis.o_tvalid <= 1'b0;
         end else begin
            idx <= idx + IW'(1);
         end
      end
   end

   assign axis.o_tdata = line_r[P_DATA_WD-1:0];
   assign axis.o_tlast = axis.o_tvalid & last_r & (idx == LAST_IDX);
   assign line_done    = accept & (idx == LAST_IDX);

endmodule

// File: rtl/tap_mem_stream_reader.sv
// Reads a run of tap-memory lines and streams each line out as fixed-width words.
module tap_mem_stream_reader
   import tap_mem_pkg::*;
#(
   parameter int P_MEM_ADDR_WD = P_MEM_ADDR_WD_DEF,
   parameter int P_MEM_WD      = P_MEM_WD_DEF,
   parameter int P_NBR_URAM    = P_NBR_URAM_DEF,
   parameter int P_DATA_WD     = P_DATA_WD_DEF,
   parameter int P_TIMEOUT     = P_TIMEOUT_DEF
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     i_start,
   input  logic [P_MEM_ADDR_WD-1:0] i_start_addr,
   input  logic [P_MEM_ADDR_WD:0]   i_num_lines,
   tap_mem_if.master                mem,
   tap_stream_if.master             axis,
   output logic                     o_busy,
   output logic                     o_done,
   output logic                     o_err_timeout
);

   localparam int LW = P_NBR_URAM * P_MEM_WD;
   localparam int CW = $clog2(P_TIMEOUT + 1);
   localparam logic [CW-1:0]            TO_LAST  = CW'(P_TIMEOUT - 1);
   localparam logic [P_MEM_ADDR_WD:0]   ONE_LINE = (P_MEM_ADDR_WD + 1)'(1);

   if ((LW % P_DATA_WD) != 0) begin : g_bad_width
      $error("line width must be a multiple of P_DATA_WD");
   end

   state_t                   state, state_nxt;
   logic [P_MEM_ADDR_WD-1:0] addr_r, addr_nxt;
   logic [P_MEM_ADDR_WD:0]   left_r, left_nxt;
   logic [CW-1:0]            wcnt_r, wcnt_nxt;
   logic                     req_nxt, err_nxt, load, line_done;

   always_ff @(posedge clk) begin
      if (rst) begin
         state              <= S_IDLE;
         addr_r             <= '0;
         left_r             <= '0;
         wcnt_r             <= '0;
         mem.o_data_request <= 1'b0;
         mem.o_addr_tap_mem <= '0;
         o_err_timeout      <= 1'b0;
      end else begin
         state              <= state_nxt;
         addr_r             <= addr_nxt;
         left_r             <= left_nxt;
         wcnt_r             <= wcnt_nxt;
         mem.o_data_request <= req_nxt;
         o_err_timeout      <= err_nxt;
         if (req_nxt) mem.o_addr_tap_mem <= addr_r;
      end
   end

   always_comb begin
      state_nxt = state;
      addr_nxt  = addr_r;
      left_nxt  = left_r;
      wcnt_nxt  = wcnt_r;
      req_nxt   = 1'b0;
      err_nxt   = o_err_timeout;
      load      = 1'b0;
      unique case (state)
         S_IDLE: if (i_start) begin
            err_nxt   = 1'b0;
            addr_nxt  = i_start_addr;
            left_nxt  = i_num_lines;
            state_nxt = (i_num_lines == '0) ? S_DONE : S_REQ;
         end
         S_REQ: if (!mem.i_data_tap_mem_busy) begin
            req_nxt   = 1'b1;
            wcnt_nxt  = '0;
            state_nxt = S_WAIT;
         end
         // The request pulse itself is the first WAIT cycle counted.
         S_WAIT: begin
            if (mem.i_data_tap_mem_valid) begin
               load      = 1'b1;
               state_nxt = S_SEND;
            end else if (wcnt_r == TO_LAST) begin
               err_nxt   = 1'b1;
               state_nxt = S_DONE;
            end else begin
               wcnt_nxt = wcnt_r + CW'(1);
            end
         end
         S_SEND: if (line_done) begin
            if (left_r > ONE_LINE) begin
               left_nxt  = left_r - ONE_LINE;
               addr_nxt  = addr_r + P_MEM_ADDR_WD'(1);
               state_nxt = S_REQ;
            end else begin
               state_nxt = S_DONE;
            end
         end
         S_DONE:  state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   assign o_busy = (state != S_IDLE);
   assign o_done = (state == S_DONE);

   tap_mem_line_serializer #(
      .P_LINE_WD(LW),
      .P_DATA_WD(P_DATA_WD)
   ) u_serializer (
      .clk      (clk),
      .rst      (rst),
      .load     (load),
      .line     (mem.i_data_tap_mem),
      .last_line(left_r == ONE_LINE),
      .line_done(line_done),
      .axis     (axis)
   );

endmodule

// File: tb/tb_tap_mem_stream_reader.sv
// Directed bench for tap_mem_stream_reader with a fixed-latency tap-memory model.
module tb_tap_mem_stream_reader;
   import tap_mem_pkg::*;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        i_start = 1'b0;
   logic [11:0] i_start_addr = '0;
   logic [12:0] i_num_lines = '0;
   logic        o_busy, o_done, o_err_timeout;

   tap_mem_if #(.P_MEM_ADDR_WD(12), .P_LINE_WD(144)) mem_bus ();
   tap_stream_if #(.P_DATA_WD(48)) axis_bus ();

   tap_mem_stream_reader #(
      .P_MEM_ADDR_WD(12),
      .P_MEM_WD     (72),
      .P_NBR_URAM   (2),
      .P_DATA_WD    (48),
      .P_TIMEOUT    (255)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .i_start      (i_start),
      .i_start_addr (i_start_addr),
      .i_num_lines  (i_num_lines),
      .mem          (mem_bus),
      .axis         (axis_bus),
      .o_busy       (o_busy),
      .o_done       (o_done),
      .o_err_timeout(o_err_timeout)
   );

   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;
   int cyc     = 0;

   always @(posedge clk) cyc++;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Memory model: line for address a holds words {A0+k, 28'h0, a}, k = 0..2 from LSB.
   bit  mem_respond = 1'b1;
   bit  stall_en    = 1'b0;
   int  mem_cnt     = 0;
   logic [11:0] mem_addr = '0;
   int  pat_i = 0;
   logic pat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};

   initial begin
      mem_bus.i_data_tap_mem       = '0;
      mem_bus.i_data_tap_mem_valid = 1'b0;
      axis_bus.i_tready            = 1'b1;
   end

   always @(posedge clk) begin
      #1;
      mem_bus.i_data_tap_mem_valid = 1'b0;
      if (rst) begin
         mem_cnt = 0;
      end else begin
         if (mem_cnt > 0) begin
            mem_cnt--;
            if (mem_cnt == 0) begin
               mem_bus.i_data_tap_mem_valid = 1'b1;
               mem_bus.i_data_tap_mem = {8'hA2, 28'h0, mem_addr, 8'hA1, 28'h0, mem_addr,
                                         8'hA0, 28'h0, mem_addr};
            end
         end
         if (mem_bus.o_data_request && mem_respond) begin
            mem_cnt  = 3;
            mem_addr = mem_bus.o_addr_tap_mem;
         end
      end
      if (stall_en) begin
         axis_bus.i_tready = pat[pat_i];
         pat_i = (pat_i + 1) % 4;
      end else begin
         axis_bus.i_tready = 1'b1;
      end
   end

   logic [11:0] req_addr[$];
   int          req_cyc[$];
   logic [47:0] wd_q[$];
   logic        wl_q[$];
   int          done_cnt = 0;
   int          done_cyc = 0;
   logic        done_err = 1'b0;
   logic        prev_stall = 1'b0;
   logic [47:0] prev_data = '0;

   always @(negedge clk) begin
      if (mem_bus.o_data_request) begin
         req_addr.push_back(mem_bus.o_addr_tap_mem);
         req_cyc.push_back(cyc);
      end
      if (prev_stall) begin
         check("hold_valid", 64'(axis_bus.o_tvalid), 64'd1);
         check("hold_data", 64'(axis_bus.o_tdata), 64'(prev_data));
      end
      if (axis_bus.o_tvalid && axis_bus.i_tready) begin
         wd_q.push_back(axis_bus.o_tdata);
         wl_q.push_back(axis_bus.o_tlast);
      end
      if (o_done) begin
         done_cnt++;
         done_cyc = cyc;
         done_err = o_err_timeout;
      end
      prev_stall = axis_bus.o_tvalid && !axis_bus.i_tready && !rst;
      prev_data  = axis_bus.o_tdata;
   end

   task automatic clear_logs();
      req_addr.delete();
      req_cyc.delete();
      wd_q.delete();
      wl_q.delete();
      done_cnt = 0;
   endtask

   task automatic start(input logic [11:0] addr, input logic [12:0] n, output int scyc);
      @(posedge clk); #1;
      i_start = 1'b1; i_start_addr = addr; i_num_lines = n; scyc = cyc;
      @(posedge clk); #1;
      i_start = 1'b0;
   endtask

   task automatic wait_done(input int budget);
      int n0 = done_cnt;
      int i = 0;
      while (done_cnt == n0 && i < budget) begin
         @(negedge clk);
         i++;
      end
      check("done_seen", 64'(done_cnt - n0), 64'd1);
      repeat (3) @(posedge clk);
   endtask

   task automatic check_outputs_zero(input string tag);
      check({tag, "_req"},   64'(mem_bus.o_data_request), 64'd0);
      check({tag, "_addr"},  64'(mem_bus.o_addr_tap_mem), 64'd0);
      check({tag, "_tdata"}, 64'(axis_bus.o_tdata), 64'd0);
      check({tag, "_tvalid"}, 64'(axis_bus.o_tvalid), 64'd0);
      check({tag, "_tlast"}, 64'(axis_bus.o_tlast), 64'd0);
      check({tag, "_busy"},  64'(o_busy), 64'd0);
      check({tag, "_done"},  64'(o_done), 64'd0);
      check({tag, "_err"},   64'(o_err_timeout), 64'd0);
   endtask

   logic [47:0] exp_a [6] = '{48'hA00000000010, 48'hA10000000010, 48'hA20000000010,
                              48'hA00000000011, 48'hA10000000011, 48'hA20000000011};
   logic [47:0] exp_c [3] = '{48'hA00000000123, 48'hA10000000123, 48'hA20000000123};

   initial begin
      int sc, fall, i, nlast;
      repeat (3) @(posedge clk);
      #1;
      check_outputs_zero("reset");
      rst = 1'b0;

      // Two lines from 0x010
      clear_logs();
      start(12'h010, 13'd2, sc);
      wait_done(200);
      check("a_nreq", 64'(req_addr.size()), 64'd2);
      if (req_addr.size() == 2) begin
         check("a_req0", 64'(req_addr[0]), 64'h010);
         check("a_req1", 64'(req_addr[1]), 64'h011);
         check("a_latency", 64'(req_cyc[0] - sc), 64'd2);
      end
      check("a_nwords", 64'(wd_q.size()), 64'd6);
      if (wd_q.size() == 6) begin
         for (int k = 0; k < 6; k++) begin
            check($sformatf("a_word%0d", k), 64'(wd_q[k]), 64'(exp_a[k]));
            check($sformatf("a_last%0d", k), 64'(wl_q[k]), 64'(k == 5));
         end
      end
      check("a_ndone", 64'(done_cnt), 64'd1);

      // Address wrap
      clear_logs();
      start(12'hFFF, 13'd2, sc);
      wait_done(200);
      check("b_nreq", 64'(req_addr.size()), 64'd2);
      if (req_addr.size() == 2) check("b_req1", 64'(req_addr[1]), 64'h000);
      check("b_nwords", 64'(wd_q.size()), 64'd6);
      if (wd_q.size() == 6) begin
         check("b_word3", 64'(wd_q[3]), 64'hA00000000000);
         check("b_last5", 64'(wl_q[5]), 64'd1);
      end

      // Backpressure 1-0-0-1
      clear_logs();
      stall_en = 1'b1;
      start(12'h123, 13'd1, sc);
      wait_done(200);
      stall_en = 1'b0;
      check("c_nwords", 64'(wd_q.size()), 64'd3);
      if (wd_q.size() == 3) begin
         for (int k = 0; k < 3; k++)
            check($sformatf("c_word%0d", k), 64'(wd_q[k]), 64'(exp_c[k]));
         check("c_last2", 64'(wl_q[2]), 64'd1);
      end

      // Memory busy for 10 cycles after start
      clear_logs();
      @(posedge clk); #1;
      mem_bus.i_data_tap_mem_busy = 1'b1;
      i_start = 1'b1; i_start_addr = 12'h200; i_num_lines = 13'd1;
      @(posedge clk); #1;
      i_start = 1'b0;
      repeat (9) @(posedge clk);
      #1;
      check("d_noreq_busy", 64'(req_addr.size()), 64'd0);
      mem_bus.i_data_tap_mem_busy = 1'b0;
      fall = cyc;
      wait_done(200);
      check("d_nreq", 64'(req_addr.size()), 64'd1);
      if (req_cyc.size() == 1) check("d_req_cycle", 64'(req_cyc[0] - fall), 64'd1);

      // Timeout with no returned data
      clear_logs();
      mem_respond = 1'b0;
      start(12'h300, 13'd1, sc);
      wait_done(400);
      mem_respond = 1'b1;
      check("e_err_at_done", 64'(done_err), 64'd1);
      check("e_nwords", 64'(wd_q.size()), 64'd0);
      if (req_cyc.size() == 1) check("e_wait_len", 64'(done_cyc - req_cyc[0]), 64'd255);
      #1;
      check("e_err_sticky", 64'(o_err_timeout), 64'd1);
      clear_logs();
      start(12'h301, 13'd1, sc);
      check("e_err_cleared", 64'(o_err_timeout), 64'd0);
      wait_done(200);
      check("e_nwords2", 64'(wd_q.size()), 64'd3);

      // Reset during word 2 of a transfer
      clear_logs();
      start(12'h400, 13'd2, sc);
      i = 0;
      while (wd_q.size() < 1 && i < 200) begin
         @(negedge clk);
         i++;
      end
      check("f_first_word", 64'(wd_q.size()), 64'd1);
      @(posedge clk); #1;
      rst = 1'b1;
      @(posedge clk); #1;
      check_outputs_zero("f_rst");
      rst = 1'b0;
      nlast = 0;
      foreach (wl_q[k]) nlast += int'(wl_q[k]);
      check("f_no_tlast", 64'(nlast), 64'd0);

      clear_logs();
      start(12'h010, 13'd1, sc);
      wait_done(200);
      check("f_nwords", 64'(wd_q.size()), 64'd3);
      if (wd_q.size() == 3) check("f_word0", 64'(wd_q[0]), 64'hA00000000010);

      // Zero-line start: done pulse only
      clear_logs();
      start(12'h055, 13'd0, sc);
      wait_done(50);
      check("g_nreq", 64'(req_addr.size()), 64'd0);
      check("g_nwords", 64'(wd_q.size()), 64'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL global_timeout: got %0d expected 0", 1);
      $fatal(1, "simulation time limit");
   end

endmodule
